// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Subtraction is a + ~b + 1, so a missing final carry means a borrow occurred.
    function automatic logic msb_flag(input logic mode, input logic cout);
        return (mode == MODE_SUB) ? ~cout : cout;
    endfunction

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder; the only arithmetic in the serial datapath.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract, LSB first, WIDTH cycles per operation.
// Optional macro SERIAL_ADDSUB_OVF_EN adds a signed-overflow flag output ovf.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             sum_bit,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   result
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic             mode;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_cout;
    logic             cnt_last;

    full_adder_cell u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign cnt_last = (cnt == CW'(WIDTH - 1));

    // The adder output is only meaningful while shifting; gate it so the
    // serial line is quiet otherwise.
    assign sum_bit = bit_valid & fa_s;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours, exactly like flops do.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            op_a      <= '0;
            op_b      <= '0;
            carry     <= 1'b0;
            mode      <= MODE_ADD;
            cnt       <= '0;
            result    <= '0;
            bit_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a      <= a;
                        op_b      <= b ^ {WIDTH{sub}};
                        carry     <= sub;
                        mode      <= sub ? MODE_SUB : MODE_ADD;
                        cnt       <= '0;
                        result    <= '0;
                        bit_valid <= 1'b1;
                        busy      <= 1'b1;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf       <= 1'b0;
`endif
                        state     <= SHIFT;
                    end
                end

                SHIFT: begin
                    op_a               <= op_a >> 1;
                    op_b               <= op_b >> 1;
                    carry              <= fa_cout;
                    result[WIDTH-1:0]  <= {fa_s, result[WIDTH-1:1]};
                    cnt                <= cnt + 1'b1;
                    if (cnt_last) begin
                        result[WIDTH] <= msb_flag(mode, fa_cout);
`ifdef SERIAL_ADDSUB_OVF_EN
                        // carry currently holds the carry into the MSB position
                        ovf           <= carry ^ fa_cout;
`endif
                        bit_valid     <= 1'b0;
                        done          <= 1'b1;
                        state         <= DONE;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    bit_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_addsub.md
SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 2..64.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have port sub  input  1  mode: 0 = a+b, 1 = a-b; sampled with start.
REQ-006 SHALL have port a  input  WIDTH  first operand, unsigned or two's complement.
REQ-007 SHALL have port b  input  WIDTH  second operand.
REQ-008 SHALL have port sum_bit  output  1  current serial result bit, LSB first.
REQ-009 SHALL have port bit_valid  output  1  high when sum_bit carries a result bit.
REQ-010 SHALL have port busy  output  1  high while an operation is in progress (SHIFT or DONE).
REQ-011 SHALL have port done  output  1  one-cycle pulse when result is final.
REQ-012 SHALL have port result  output  WIDTH+1  parallel result; MSB is carry (add) or borrow (sub).

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-014 IDLE with start=1 SHALL latch a, b XOR {WIDTH{sub}}, carry=sub, mode=sub, clear bit counter and shift register, then go to SHIFT.
REQ-015 IDLE with start=0 SHALL hold all registers; bit_valid=0, done=0, busy=0.
REQ-016 SHIFT SHALL, each cycle, full-add the operand LSBs and carry, drive sum_bit with bit_valid=1, shift the operands right by one, update carry, and shift the sum bit into result from the MSB side.
REQ-017 SHIFT SHALL last exactly WIDTH cycles, then go to DONE.
REQ-018 On leaving SHIFT, result[WIDTH] SHALL be the final carry for add and its inverse (borrow) for sub.
REQ-019 DONE SHALL last one cycle with done=1, bit_valid=0, busy=1, then go to IDLE.
REQ-020 Latency: start accepted in cycle 0, bits in cycles 1..WIDTH, done in cycle WIDTH+1, next start accepted in cycle WIDTH+2.
REQ-021 start in SHIFT or DONE SHALL be ignored, with no queuing.
REQ-022 Input changes after acceptance SHALL NOT affect the running operation.
REQ-023 result SHALL hold its value from DONE until the next accepted start, and SHALL be undefined-free (never X) in between.
REQ-024 sum_bit SHALL be 0 whenever bit_valid=0.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH in result[WIDTH-1:0], with no saturation.

Reset
REQ-026 rst=1 at a clock edge SHALL force IDLE and zero operands, carry, counter, result, sum_bit, bit_valid, busy, done, and ovf if present.
REQ-027 rst SHALL take priority over start and abort any operation mid-SHIFT or in DONE without asserting done.

Configuration
REQ-028 With macro SERIAL_ADDSUB_OVF_EN defined, the block SHALL add port ovf (output, 1 bit), asserted from DONE until the next accepted start when the signed two's-complement result overflows (carry into MSB != carry out of MSB).
REQ-029 Without SERIAL_ADDSUB_OVF_EN, the ovf port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-030 Package serial_addsub_pkg SHALL hold the state typedef (IDLE/SHIFT/DONE) and the mode constants MODE_ADD=0, MODE_SUB=1.
REQ-031 The 1-bit full adder SHALL be a sub-module full_adder_cell (a, b, cin -> s, cout), instantiated once.

Verification (WIDTH=8)
REQ-032 add 3+5 -> bits 0,0,0,1,0,0,0,0 in cycles 1..8; done in cycle 9; result=9'h008.
REQ-033 add 255+1 -> result=9'h100; sub 5-3 -> result=9'h002.
REQ-034 sub 3-5 -> result=9'h1FE (borrow=1).
REQ-035 start pulsed in cycle 4 of an op -> ignored; exactly one done; result unchanged by second operands.
REQ-036 rst in cycle 4 of SHIFT -> next cycle IDLE, all outputs 0, no done; a fresh start then completes normally.
REQ-037 With SERIAL_ADDSUB_OVF_EN: add 127+1 -> ovf=1, result[7:0]=8'h80; add 100+20 -> ovf=0.
